// File: rtl/morty_pkg.sv
// Shared encodings for the Morty load/store unit: funct3 codes, access size and FSM states.
package morty_pkg;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;

    typedef enum logic [1:0] {StIdle, StBus, StDone} lsu_state_e;

    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} lsu_size_e;

    // Unused codes (011, 11x) fall through to word size.
    function automatic lsu_size_e lsu_size(input logic [2:0] funct3);
        unique case (funct3[1:0])
            2'b00:   lsu_size = SzByte;
            2'b01:   lsu_size = SzHalf;
            default: lsu_size = SzWord;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store selects/data replication, load extraction/extension, misalignment.
module lsu_align
    import morty_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        mis_o
);

    lsu_size_e   size;
    logic        sext;
    logic [31:0] shifted;

    always_comb begin
        size    = lsu_size(funct3_i);
        sext    = ~funct3_i[2];
        shifted = rdata_i >> {off_i, 3'b000};
        sel_o   = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        mis_o   = 1'b0;
        unique case (size)
            SzByte: begin
                sel_o   = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            SzHalf: begin
                sel_o   = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sext & shifted[15]}}, shifted[15:0]};
                mis_o   = off_i[0];
            end
            default: begin
                mis_o = (off_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: one EX request becomes one Wishbone-classic cycle with stall, faults, timeout.
module mem_lsu
    import morty_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        kill_i,
    input  logic        ex_valid_i,
    input  logic        ex_load_i,
    input  logic        ex_store_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_o,
    output logic        exc_ld_mis_o,
    output logic        exc_st_mis_o,
    output logic        exc_ld_flt_o,
    output logic        exc_st_flt_o,
    output logic [31:0] exc_addr_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    lsu_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d, wdat_q, wdat_d, data_q, data_d;
    logic [3:0]     sel_q, sel_d;
    logic [2:0]     funct3_q, funct3_d;
    logic           we_q, we_d, cyc_q, cyc_d, fault_q, fault_d, killed_q, killed_d;

    logic        req, in_idle, killed;
    logic [2:0]  al_funct3;
    logic [1:0]  al_off;
    logic [3:0]  al_sel;
    logic [31:0] al_wdata, al_rdata;
    logic        al_mis;

    // Single aligner: fed from EX while idle, from the latched request afterwards.
    assign in_idle   = (state_q == StIdle);
    assign al_funct3 = in_idle ? ex_funct3_i : funct3_q;
    assign al_off    = in_idle ? ex_addr_i[1:0] : addr_q[1:0];

    lsu_align u_align (
        .funct3_i (al_funct3),
        .off_i    (al_off),
        .wdata_i  (ex_wdata_i),
        .rdata_i  (wbm_dat_i),
        .sel_o    (al_sel),
        .wdata_o  (al_wdata),
        .rdata_o  (al_rdata),
        .mis_o    (al_mis)
    );

    assign req    = ex_valid_i & (ex_load_i | ex_store_i) & ~kill_i;
    assign killed = killed_q | kill_i;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdat_d       = wdat_q;
        data_d       = data_q;
        sel_d        = sel_q;
        funct3_d     = funct3_q;
        we_d         = we_q;
        cyc_d        = cyc_q;
        fault_d      = fault_q;
        killed_d     = killed_q;
        lsu_stall_o  = 1'b0;
        exc_ld_mis_o = 1'b0;
        exc_st_mis_o = 1'b0;
        exc_ld_flt_o = 1'b0;
        exc_st_flt_o = 1'b0;
        exc_addr_o   = 32'h0;
        unique case (state_q)
            StIdle: begin
                cnt_d    = '0;
                fault_d  = 1'b0;
                killed_d = 1'b0;
                if (req && al_mis) begin
                    exc_ld_mis_o = ex_load_i;
                    exc_st_mis_o = ~ex_load_i;
                    exc_addr_o   = ex_addr_i;
                end else if (req) begin
                    addr_d      = ex_addr_i;
                    wdat_d      = al_wdata;
                    sel_d       = al_sel;
                    funct3_d    = ex_funct3_i;
                    we_d        = ex_store_i;
                    cyc_d       = 1'b1;
                    lsu_stall_o = 1'b1;
                    state_d     = StBus;
                end
            end
            StBus: begin
                lsu_stall_o = 1'b1;
                cnt_d       = cnt_q + CntW'(1);
                killed_d    = killed;
                // err outranks a simultaneous ack
                if (wbm_err_i || (!wbm_ack_i && cnt_q == CntLast)) begin
                    fault_d = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = StDone;
                end else if (wbm_ack_i) begin
                    if (!we_q && !killed) begin
                        data_d = al_rdata;
                    end
                    cyc_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (fault_q && !killed) begin
                    exc_ld_flt_o = ~we_q;
                    exc_st_flt_o = we_q;
                    exc_addr_o   = addr_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= 32'h0;
            wdat_q   <= 32'h0;
            data_q   <= 32'h0;
            sel_q    <= 4'h0;
            funct3_q <= 3'h0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            fault_q  <= 1'b0;
            killed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            fault_q  <= fault_d;
            killed_q <= killed_d;
        end
    end

    assign lsu_data_o = data_q;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_we_o   = we_q;
    assign wbm_sel_o  = sel_q;
    assign wbm_adr_o  = {addr_q[31:2], 2'b00};
    assign wbm_dat_o  = wdat_q;

endmodule
